seg_scan_capture: RTL and testbench

- Passive monitor for the multiplexed 7-segment display bus.
- Samples the active-low segment lines `CA` and anode lines `AN` and waits for each digit slot to hold a stable pattern.
- Maps each stable pattern back to its hex nibble and assembles the full displayed value.
- Sits beside the display driver on the board-level bus: a self-check and readback path so the CPU test harness can read what the display is showing.

---
 rtl/seg_pkg.sv | 40 ++++
 rtl/seg_pattern_decode.sv | 47 ++++
 rtl/seg_scan_capture.sv | 155 +++++++++++++++
 tb/tb_seg_scan_capture.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// +--------------------------------------------------------------------+
// | seg_pkg: shared constants and state type for the 7-seg bus monitor |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package seg_pkg;

  // Segment patterns, active-low, bit6=a ... bit0=g
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_PATTERN  = 2'b01;
  localparam logic [1:0] ERR_MULTI_AN = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETTLE   = 2'd1,
    ST_CAPTURED = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/seg_pattern_decode.sv
// +--------------------------------------------------------------------+
// | seg_pattern_decode: maps an active-low segment pattern to a nibble |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] ca,
  output logic       legal,
  output logic       blank,
  output logic [3:0] nibble
);

  always_comb begin
    legal  = 1'b1;
    blank  = 1'b0;
    nibble = 4'h0;
    case (ca)
      SEG_0:     nibble = 4'h0;
      SEG_1:     nibble = 4'h1;
      SEG_2:     nibble = 4'h2;
      SEG_3:     nibble = 4'h3;
      SEG_4:     nibble = 4'h4;
      SEG_5:     nibble = 4'h5;
      SEG_6:     nibble = 4'h6;
      SEG_7:     nibble = 4'h7;
      SEG_8:     nibble = 4'h8;
      SEG_9:     nibble = 4'h9;
      SEG_A:     nibble = 4'hA;
      SEG_B:     nibble = 4'hB;
      SEG_C:     nibble = 4'hC;
      SEG_D:     nibble = 4'hD;
      SEG_E:     nibble = 4'hE;
      SEG_F:     nibble = 4'hF;
      SEG_BLANK: begin
        legal = 1'b0;
        blank = 1'b1;
      end
      default:   legal = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seg_scan_capture.sv
// +--------------------------------------------------------------------+
// | seg_scan_capture: passive monitor that reassembles the value shown |
// | on a multiplexed 7-segment bus.  Rev 1.0                           |
// +--------------------------------------------------------------------+
`default_nettype none

module seg_scan_capture
  import seg_pkg::*;
#(
  parameter int DIGITS        = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            CA,
  input  logic [DIGITS-1:0]     AN,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     digit_valid,
  output logic                  frame_done,
  output logic                  err,
  output logic [1:0]            err_code
);

  localparam int              CW         = $clog2(STABLE_CYCLES + 1);
  localparam int              PW         = DIGITS + 7;
  localparam logic [CW-1:0]   C_CNT_MAX  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0]   C_CNT_FIRE = CW'(STABLE_CYCLES - 1);

  logic [6:0]          ca_m_q, ca_s_q;
  logic [DIGITS-1:0]   an_m_q, an_s_q;
  logic [PW-1:0]       prev_q;
  logic [CW-1:0]       cnt_q, cnt_d;
  state_e              state_q, state_d;
  logic [4*DIGITS-1:0] value_q, value_d;
  logic [DIGITS-1:0]   dv_q, dv_d;
  logic                frame_q, frame_d;
  logic                err_q, err_d;
  logic [1:0]          code_q, code_d;

  logic [PW-1:0]       w_pair;
  logic [DIGITS-1:0]   w_an_act;
  logic                w_any, w_one, w_same, w_fire;
  logic                w_legal, w_blank;
  logic [3:0]          w_nibble;

  seg_pattern_decode u_decode (
    .ca     (ca_s_q),
    .legal  (w_legal),
    .blank  (w_blank),
    .nibble (w_nibble)
  );

  always_comb begin
    w_pair   = {an_s_q, ca_s_q};
    w_an_act = ~an_s_q;
    w_any    = |w_an_act;
    w_one    = w_any && ((w_an_act & (w_an_act - DIGITS'(1))) == '0);
    w_same   = (w_pair == prev_q);
    // The fire point is one sample before saturation so the capture edge
    // lands STABLE_CYCLES edges after the pair first reaches the sync output.
    w_fire   = w_same && w_any && (state_q != ST_CAPTURED) && (cnt_q >= C_CNT_FIRE);
  end

  always_comb begin
    if (!w_same)
      cnt_d = '0;
    else if (cnt_q == C_CNT_MAX)
      cnt_d = cnt_q;
    else
      cnt_d = cnt_q + CW'(1);

    state_d = state_q;
    case (state_q)
      ST_CAPTURED: begin
        if (!w_same)
          state_d = w_any ? ST_SETTLE : ST_IDLE;
      end
      default: begin
        if (w_fire)
          state_d = ST_CAPTURED;
        else
          state_d = w_any ? ST_SETTLE : ST_IDLE;
      end
    endcase
  end

  always_comb begin
    value_d = value_q;
    dv_d    = dv_q;
    frame_d = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;
    if (w_fire) begin
      if (!w_one) begin
        err_d  = 1'b1;
        code_d = ERR_MULTI_AN;
      end else if (w_legal || w_blank) begin
        for (int i = 0; i < DIGITS; i++) begin
          if (w_an_act[i]) begin
            dv_d[i] = 1'b1;
            if (w_legal)
              value_d[4*i +: 4] = w_nibble;
          end
        end
        // Completing a frame restarts the valid map on the capture edge itself.
        if (&dv_d) begin
          frame_d = 1'b1;
          dv_d    = '0;
        end
      end else begin
        err_d  = 1'b1;
        code_d = ERR_PATTERN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ca_m_q  <= '1;
      ca_s_q  <= '1;
      an_m_q  <= '1;
      an_s_q  <= '1;
      prev_q  <= '1;
      cnt_q   <= '0;
      state_q <= ST_IDLE;
      value_q <= '0;
      dv_q    <= '0;
      frame_q <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      ca_m_q  <= CA;
      ca_s_q  <= ca_m_q;
      an_m_q  <= AN;
      an_s_q  <= an_m_q;
      prev_q  <= w_pair;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      value_q <= value_d;
      dv_q    <= dv_d;
      frame_q <= frame_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign value       = value_q;
  assign digit_valid = dv_q;
  assign frame_done  = frame_q;
  assign err         = err_q;
  assign err_code    = code_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_capture.sv
// +--------------------------------------------------------------------+
// | tb_seg_scan_capture: vector table + scoreboard bench               |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_seg_scan_capture;

  localparam int DIGITS = 8;
  localparam int STABLE = 4;
  localparam int LAT    = STABLE + 3;

  typedef struct {
    logic [7:0] an;
    logic [6:0] ca;
    int         hold;
    bit         ev;
    bit         is_err;
    logic [1:0] code;
    bit         wr;
    logic [3:0] nib;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [31:0] val;
    logic [7:0]  dv;
    logic        err;
    logic [1:0]  code;
    logic        frame;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  CA;
  logic [7:0]  AN;
  logic [31:0] value;
  logic [7:0]  digit_valid;
  logic        frame_done;
  logic        err;
  logic [1:0]  err_code;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  logic [31:0] pv_val;
  logic [7:0]  pv_dv;
  logic [31:0] m_val;
  logic [7:0]  m_dv;
  logic [1:0]  m_code;
  exp_t        sb[$];
  vec_t        vt[23];
  logic [6:0]  pat[16];

  seg_scan_capture #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .CA          (CA),
    .AN          (AN),
    .value       (value),
    .digit_valid (digit_valid),
    .frame_done  (frame_done),
    .err         (err),
    .err_code    (err_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Any visible output change is one DUT "result"; it must match the queue head.
  task automatic monitor();
    exp_t e;
    logic ev;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
          e = sb.pop_front();
          checks++;
          errors++;
          $display("FAIL missed_capture: nothing by cycle %0d, expected at cycle %0d", cyc, e.cyc);
        end
        ev = err | frame_done | (digit_valid != pv_dv) | (value != pv_val);
        if (ev) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: cycle %0d value=%h dv=%b err=%b frame=%b",
                     cyc, value, digit_valid, err, frame_done);
          end else begin
            e = sb.pop_front();
            chk("capture_cycle", 64'(cyc), 64'(e.cyc));
            chk("value",         64'(value), 64'(e.val));
            chk("digit_valid",   64'(digit_valid), 64'(e.dv));
            chk("err",           64'(err), 64'(e.err));
            chk("err_code",      64'(err_code), 64'(e.code));
            chk("frame_done",    64'(frame_done), 64'(e.frame));
          end
        end
        pv_val = value;
        pv_dv  = digit_valid;
      end
    end
  endtask

  task automatic apply(input logic [7:0] an, input logic [6:0] ca, input int hold,
                       input bit ev, input bit is_err, input logic [1:0] code,
                       input bit wr, input logic [3:0] nib);
    exp_t e;
    int   slot;
    @(posedge clk);
    #1;
    AN = an;
    CA = ca;
    if (ev) begin
      e.cyc   = cyc + LAT;
      e.err   = is_err;
      e.frame = 1'b0;
      if (is_err) begin
        m_code = code;
      end else begin
        slot = 0;
        for (int i = 0; i < DIGITS; i++) if (!an[i]) slot = i;
        if (wr) m_val[4*slot +: 4] = nib;
        m_dv[slot] = 1'b1;
        if (&m_dv) begin
          e.frame = 1'b1;
          m_dv    = '0;
        end
      end
      e.val  = m_val;
      e.dv   = m_dv;
      e.code = m_code;
      sb.push_back(e);
    end
    repeat (hold - 1) @(posedge clk);
  endtask

  initial begin
    pat[0]  = 7'b0000001; pat[1]  = 7'b1001111; pat[2]  = 7'b0010010; pat[3]  = 7'b0000110;
    pat[4]  = 7'b1001100; pat[5]  = 7'b0100100; pat[6]  = 7'b0100000; pat[7]  = 7'b0001111;
    pat[8]  = 7'b0000000; pat[9]  = 7'b0000100; pat[10] = 7'b0001000; pat[11] = 7'b1100000;
    pat[12] = 7'b0110001; pat[13] = 7'b1000010; pat[14] = 7'b0110000; pat[15] = 7'b0111000;

    //            AN      CA          hold ev err code   wr nib
    vt[0]  = '{8'hFE, 7'b0000110, 10, 1, 0, 2'b00, 1, 4'h3};
    vt[1]  = '{8'hFF, 7'b1111111,  3, 0, 0, 2'b00, 0, 4'h0};
    vt[2]  = '{8'hFE, 7'b1001111,  8, 1, 0, 2'b00, 1, 4'h1};
    vt[3]  = '{8'hFD, 7'b0010010,  8, 1, 0, 2'b00, 1, 4'h2};
    vt[4]  = '{8'hFB, 7'b0000110,  8, 1, 0, 2'b00, 1, 4'h3};
    vt[5]  = '{8'hF7, 7'b1001100,  8, 1, 0, 2'b00, 1, 4'h4};
    vt[6]  = '{8'hEF, 7'b0100100,  8, 1, 0, 2'b00, 1, 4'h5};
    vt[7]  = '{8'hDF, 7'b0100000,  8, 1, 0, 2'b00, 1, 4'h6};
    vt[8]  = '{8'hBF, 7'b0001111,  8, 1, 0, 2'b00, 1, 4'h7};
    vt[9]  = '{8'h7F, 7'b0000000,  8, 1, 0, 2'b00, 1, 4'h8};
    vt[10] = '{8'hFF, 7'b1111111,  3, 0, 0, 2'b00, 0, 4'h0};
    vt[11] = '{8'hFD, 7'b0001000,  3, 0, 0, 2'b00, 0, 4'h0};
    vt[12] = '{8'hFF, 7'b1111111,  4, 0, 0, 2'b00, 0, 4'h0};
    vt[13] = '{8'hFD, 7'b0001000,  4, 0, 0, 2'b00, 0, 4'h0};
    vt[14] = '{8'hFF, 7'b1111111,  4, 0, 0, 2'b00, 0, 4'h0};
    vt[15] = '{8'hFD, 7'b0001000,  5, 1, 0, 2'b00, 1, 4'hA};
    vt[16] = '{8'hFF, 7'b1111111,  3, 0, 0, 2'b00, 0, 4'h0};
    vt[17] = '{8'hFB, 7'b1111110,  8, 1, 1, 2'b01, 0, 4'h0};
    vt[18] = '{8'hFF, 7'b1111111,  3, 0, 0, 2'b00, 0, 4'h0};
    vt[19] = '{8'hF3, 7'b0100100,  8, 1, 1, 2'b10, 0, 4'h0};
    vt[20] = '{8'hFF, 7'b1111111,  3, 0, 0, 2'b00, 0, 4'h0};
    vt[21] = '{8'hDF, 7'b1111111,  8, 1, 0, 2'b00, 0, 4'h0};
    vt[22] = '{8'hFF, 7'b1111111,  3, 0, 0, 2'b00, 0, 4'h0};

    rst_n  = 1'b0;
    AN     = '1;
    CA     = '1;
    m_val  = '0;
    m_dv   = '0;
    m_code = 2'b00;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #2;
    chk("reset_value",       64'(value), 64'h0);
    chk("reset_digit_valid", 64'(digit_valid), 64'h0);
    chk("reset_frame_done",  64'(frame_done), 64'h0);
    chk("reset_err",         64'(err), 64'h0);
    chk("reset_err_code",    64'(err_code), 64'h0);
    rst_n  = 1'b1;
    pv_val = '0;
    pv_dv  = '0;
    mon_en = 1'b1;

    for (int v = 0; v < 23; v++)
      apply(vt[v].an, vt[v].ca, vt[v].hold, vt[v].ev, vt[v].is_err,
            vt[v].code, vt[v].wr, vt[v].nib);
    repeat (4) @(posedge clk);
    #1;
    chk("value_after_table", 64'(value), 64'h876543A1);
    chk("dv_after_table",    64'(digit_valid), 64'h22);

    // Reset in the middle of a partially settled digit.
    AN = 8'hFE;
    CA = 7'b0001111;
    repeat (2) @(posedge clk);
    #3;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("midreset_value",       64'(value), 64'h0);
    chk("midreset_digit_valid", 64'(digit_valid), 64'h0);
    chk("midreset_frame_done",  64'(frame_done), 64'h0);
    chk("midreset_err",         64'(err), 64'h0);
    chk("midreset_err_code",    64'(err_code), 64'h0);
    AN     = '1;
    CA     = '1;
    m_val  = '0;
    m_dv   = '0;
    m_code = 2'b00;
    sb.delete();
    repeat (3) @(posedge clk);
    #2;
    rst_n  = 1'b1;
    pv_val = '0;
    pv_dv  = '0;
    mon_en = 1'b1;

    for (int n = 0; n < 16; n++)
      apply(8'h7F, pat[n], 6, 1, 0, 2'b00, 1, 4'(n));
    apply(8'hFF, 7'b1111111, 3, 0, 0, 2'b00, 0, 4'h0);

    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'h0);
    chk("sweep_final_value",  64'(value), 64'hF0000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
